// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display path.
// Patterns are {a,b,c,d,e,f,g,dp}, MSB=a, active-high.
package seg_pkg;

    localparam int SEG_W = 8;

    localparam logic [SEG_W-1:0] SEG_0     = 8'b11111100;
    localparam logic [SEG_W-1:0] SEG_1     = 8'b01100000;
    localparam logic [SEG_W-1:0] SEG_2     = 8'b11011010;
    localparam logic [SEG_W-1:0] SEG_3     = 8'b11110010;
    localparam logic [SEG_W-1:0] SEG_4     = 8'b01100110;
    localparam logic [SEG_W-1:0] SEG_5     = 8'b10110110;
    localparam logic [SEG_W-1:0] SEG_6     = 8'b10111110;
    localparam logic [SEG_W-1:0] SEG_7     = 8'b11100000;
    localparam logic [SEG_W-1:0] SEG_8     = 8'b11111110;
    localparam logic [SEG_W-1:0] SEG_9     = 8'b11100110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'b00000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] v);
        logic [SEG_W-1:0] p;
        case (v)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot prescaler: slot_cnt runs 0..SCAN_DIV-1 and is held at 0 by clear.
// in_blank looks one cycle ahead: the count after the next edge lies in the blanking window.
module seg_slot_timer #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16,
    parameter int CNT_W     = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             in_blank,
    output logic             slot_end
);

    assign slot_end = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    // A wrap lands on count 0, which is always blank since BLANK_CYC >= 1.
    assign in_blank = slot_end || ((int'(slot_cnt) + 1) < BLANK_CYC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
        end else if (clear || slot_end) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin digit scanner with per-slot blanking and 16-step PWM brightness.
// Patterns and duty are captured once per frame so mid-frame input changes never tear.
module seg_scan_ctrl #(
    parameter int DIGITS    = 3,
    parameter int SEG_W     = seg_pkg::SEG_W,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [3:0]              duty,
    input  logic [DIGITS*SEG_W-1:0] seg_in,
    output logic [SEG_W-1:0]        seg_out,
    output logic [DIGITS-1:0]       dig_sel,
    output logic                    frame_start
);
    import seg_pkg::*;

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    scan_state_t             state;
    logic [DIG_W-1:0]        digit;
    logic [DIGITS*SEG_W-1:0] snap;
    logic [3:0]              duty_q;

    logic [CNT_W-1:0]        slot_cnt;
    logic                    in_blank;
    logic                    slot_end;

    logic [CNT_W-1:0]        k_nxt;
    logic                    lit_nxt;
    logic [SEG_W-1:0]        cur_pat;
    logic                    last_digit;

    seg_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state == IDLE) || !en),
        .slot_cnt (slot_cnt),
        .in_blank (in_blank),
        .slot_end (slot_end)
    );

    // Outputs are registered, so the PWM decision uses the count the timer will hold after this edge.
    always_comb begin
        k_nxt      = slot_cnt + 1'b1 - CNT_W'(BLANK_CYC);
        lit_nxt    = (k_nxt[3:0] <= duty_q);
        cur_pat    = snap[int'(digit)*SEG_W +: SEG_W];
        last_digit = (digit == DIG_W'(DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            digit       <= '0;
            snap        <= '0;
            duty_q      <= '0;
            seg_out     <= '0;
            dig_sel     <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            state       <= IDLE;
            digit       <= '0;
            seg_out     <= '0;
            dig_sel     <= '0;
            frame_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= BLANK;
                    digit       <= '0;
                    snap        <= seg_in;
                    duty_q      <= duty;
                    frame_start <= 1'b1;
                    seg_out     <= '0;
                    dig_sel     <= '0;
                end
                BLANK, DRIVE: begin
                    frame_start <= 1'b0;
                    if (slot_end) begin
                        if (last_digit) begin
                            digit       <= '0;
                            snap        <= seg_in;
                            duty_q      <= duty;
                            frame_start <= 1'b1;
                        end else begin
                            digit <= digit + 1'b1;
                        end
                    end
                    if (in_blank) begin
                        state   <= BLANK;
                        seg_out <= '0;
                        dig_sel <= '0;
                    end else begin
                        state   <= DRIVE;
                        seg_out <= lit_nxt ? cur_pat : '0;
                        dig_sel <= lit_nxt ? (DIGITS'(1) << digit) : '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    seg_out <= '0;
                    dig_sel <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: stimulus queues expected per-edge outputs, a negedge monitor compares.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int DIGITS    = 3;
    localparam int SW        = 8;
    localparam int SCAN_DIV  = 40;
    localparam int BLANK_CYC = 4;
    localparam int FRAME     = SCAN_DIV * DIGITS;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en  = 1'b0;
    logic [3:0]           duty = 4'd0;
    logic [DIGITS*SW-1:0] seg_in = '0;
    logic [SW-1:0]        seg_out;
    logic [DIGITS-1:0]    dig_sel;
    logic                 frame_start;

    typedef struct packed {
        logic [DIGITS-1:0] dig;
        logic [SW-1:0]     seg;
        logic              fs;
    } obs_t;

    typedef struct {
        obs_t v;
        int   tag;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [SW-1:0] m_pat [DIGITS];
    int         m_duty;

    seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SEG_W     (SW),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .duty        (duty),
        .seg_in      (seg_in),
        .seg_out     (seg_out),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Expected outputs after edge e counted from E0 (the first edge that sees en=1).
    function automatic obs_t model(input int e);
        obs_t r;
        int   c;
        int   d;
        r  = '0;
        c  = e % SCAN_DIV;
        d  = (e / SCAN_DIV) % DIGITS;
        r.fs = ((e % FRAME) == 0);
        if (c >= BLANK_CYC && ((c - BLANK_CYC) % 16) <= m_duty) begin
            r.dig = DIGITS'(1 << d);
            r.seg = m_pat[d];
        end
        return r;
    endfunction

    task automatic step(input obs_t v, input int tag);
        exp_t x;
        @(posedge clk);
        x.v   = v;
        x.tag = tag;
        exp_q.push_back(x);
        #1;
    endtask

    task automatic run(input int e0, input int e1);
        for (int e = e0; e <= e1; e++) begin
            if ((e % FRAME) == 0) begin
                for (int d = 0; d < DIGITS; d++) m_pat[d] = seg_in[d*SW +: SW];
                m_duty = int'(duty);
            end
            step(model(e), e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, -1);
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t x;
            obs_t got;
            x   = exp_q.pop_front();
            got = {dig_sel, seg_out, frame_start};
            tests++;
            if (got !== x.v) begin
                fails++;
                $display("FAIL scan e=%0d t=%0t: got dig=%b seg=%h fs=%b, want dig=%b seg=%h fs=%b",
                         x.tag, $time, got.dig, got.seg, got.fs, x.v.dig, x.v.seg, x.v.fs);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset seg_out", int'(seg_out), 0);
        chk("reset dig_sel", int'(dig_sel), 0);
        chk("reset frame_start", int'(frame_start), 0);
        #4 rst = 1'b1;

        // Disabled after reset: everything dark.
        idle(100);

        // Full brightness, digits 0/1/2 = "0","1","2".
        en     = 1'b1;
        duty   = 4'd15;
        seg_in = {seg_digit(4'd2), seg_digit(4'd1), seg_digit(4'd0)};
        run(0, 10);
        // Mid-frame pattern change: digit0 must keep showing "0" until the next frame.
        seg_in[SW-1:0] = seg_digit(4'd1);
        run(11, 129);
        // Mid-frame duty change: takes effect at the frame starting at E240.
        duty = 4'd3;
        run(130, 285);

        // Drop enable while digit1 is lit, then restart from digit 0.
        en = 1'b0;
        idle(10);
        en = 1'b1;
        run(0, 45);

        // Asynchronous reset between edges while digit1 is lit.
        @(negedge clk);
        #1;
        chk("pre-reset dig_sel lit", int'(dig_sel), 2);
        rst = 1'b0;
        #1;
        chk("async rst seg_out", int'(seg_out), 0);
        chk("async rst dig_sel", int'(dig_sel), 0);
        chk("async rst frame_start", int'(frame_start), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("held rst dig_sel", int'(dig_sel), 0);
        chk("held rst frame_start", int'(frame_start), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
